// File: rtl/multicycle_controller_if.sv
// Instruction/status inputs and datapath control outputs of the multicycle controller.
// Latency: none, pure signal bundle.
// Backpressure: mem_ready carries memory stalls into the controller.
interface multicycle_controller_if;
   // instruction fields and datapath status
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   // datapath controls
   logic       pc_write;
   logic       ir_write;
   logic       reg_write;
   logic       mem_write;
   logic       adr_src;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] imm_src;
   logic [2:0] alu_control;
   logic       illegal;
   logic [3:0] state;

   // datapath side: supplies instruction/status, consumes controls
   modport master (
      output op, funct3, funct7b5, zero, mem_ready,
      input  pc_write, ir_write, reg_write, mem_write, adr_src,
      input  result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal, state
   );

   // controller side
   modport slave (
      input  op, funct3, funct7b5, zero, mem_ready,
      output pc_write, ir_write, reg_write, mem_write, adr_src,
      output result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller: FSM sequencing lw/sw/R/I/jal/beq.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles FETCH-to-FETCH with memory ready.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold their state while mem_ready=0.
module multicycle_controller (
   input  logic                   clk,
   input  logic                   rst_n,
   multicycle_controller_if.slave bus
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_illegal_op;
   logic [2:0] w_alu_func;
   logic       w_pc_write;
   logic       w_ir_write;
   logic       w_reg_write;
   logic       w_mem_write;

   // next-state selection; illegal opcodes in DECODE fall back to FETCH
   always_comb begin
      w_next       = S_FETCH;
      w_illegal_op = 1'b0;
      case (r_state)
         S_FETCH:    w_next = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTER;
               OP_I:         w_next = S_EXECUTEI;
               OP_JAL:       w_next = S_JAL;
               OP_BEQ:       w_next = S_BEQ;
               default: begin
                  w_next       = S_FETCH;
                  w_illegal_op = 1'b1;
               end
            endcase
         end
         S_MEMADR:   w_next = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: w_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         S_JAL:      w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BEQ:      w_next = S_FETCH;
         default:    w_next = S_FETCH;
      endcase
   end

   // state register; reset lands in FETCH immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // functional ALU decode; op[5] separates sub (R-type) from addi
   always_comb begin
      case (bus.funct3)
         3'b000:  w_alu_func = (bus.funct7b5 & bus.op[5]) ? ALU_SUB : ALU_ADD;
         3'b010:  w_alu_func = ALU_SLT;
         3'b110:  w_alu_func = ALU_OR;
         3'b111:  w_alu_func = ALU_AND;
         default: w_alu_func = ALU_ADD;
      endcase
   end

   // Moore control decode; strobes are gated by rst_n so reset kills them at once
   always_comb begin
      w_pc_write      = 1'b0;
      w_ir_write      = 1'b0;
      w_reg_write     = 1'b0;
      w_mem_write     = 1'b0;
      bus.adr_src     = 1'b0;
      bus.result_src  = 2'b00;
      bus.alu_src_a   = 2'b00;
      bus.alu_src_b   = 2'b00;
      bus.alu_control = ALU_ADD;
      case (r_state)
         S_FETCH: begin
            bus.alu_src_b  = 2'b10;
            bus.result_src = 2'b10;
            w_pc_write     = bus.mem_ready;
            w_ir_write     = bus.mem_ready;
         end
         S_DECODE: begin
            bus.alu_src_a = 2'b01;
            bus.alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 2'b01;
         end
         S_MEMREAD:  bus.adr_src = 1'b1;
         S_MEMWB: begin
            bus.result_src = 2'b01;
            w_reg_write    = 1'b1;
         end
         S_MEMWRITE: begin
            bus.adr_src = 1'b1;
            w_mem_write = 1'b1;
         end
         S_EXECUTER: begin
            bus.alu_src_a   = 2'b10;
            bus.alu_control = w_alu_func;
         end
         S_EXECUTEI: begin
            bus.alu_src_a   = 2'b10;
            bus.alu_src_b   = 2'b01;
            bus.alu_control = w_alu_func;
         end
         S_ALUWB:    w_reg_write = 1'b1;
         S_JAL: begin
            bus.alu_src_a = 2'b01;
            bus.alu_src_b = 2'b10;
            w_pc_write    = 1'b1;
         end
         S_BEQ: begin
            bus.alu_src_a   = 2'b10;
            bus.alu_control = ALU_SUB;
            w_pc_write      = bus.zero;
         end
         default: ;
      endcase
      bus.pc_write  = w_pc_write  & rst_n;
      bus.ir_write  = w_ir_write  & rst_n;
      bus.reg_write = w_reg_write & rst_n;
      bus.mem_write = w_mem_write & rst_n;
      bus.illegal   = w_illegal_op & rst_n;
      bus.state     = r_state;
   end

   // immediate format follows the opcode in every state
   always_comb begin
      case (bus.op)
         OP_SW:   bus.imm_src = 2'b01;
         OP_BEQ:  bus.imm_src = 2'b10;
         OP_JAL:  bus.imm_src = 2'b11;
         default: bus.imm_src = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class state by state.
// Latency: checks land 2 time units after each rising edge; inputs change between edges.
// Backpressure: mem_ready is dropped in FETCH and MEMWRITE to exercise stalls.
module tb_multicycle_controller;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   multicycle_controller_if bus ();

   multicycle_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // hard stop guard
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // {state, pc_write, ir_write, reg_write, mem_write, adr_src, result_src, alu_src_a, alu_src_b, alu_control, illegal}
   function automatic logic [18:0] ev(input logic [3:0] st, input logic pc, input logic ir,
                                      input logic rw, input logic mw, input logic adr,
                                      input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                                      input logic [2:0] alu, input logic ill);
      return {st, pc, ir, rw, mw, adr, rs, a, b, alu, ill};
   endfunction

   function automatic logic [18:0] obs();
      return {bus.state, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.adr_src,
              bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.illegal};
   endfunction

   task automatic chk(input string tag, input logic [18:0] exp_v);
      logic [18:0] got;
      got = obs();
      checks++;
      assert (got === exp_v) else begin
         errors++;
         $error("FAIL %s got=%05h exp=%05h", tag, got, exp_v);
      end
   endtask

   task automatic chk_imm(input string tag, input logic [1:0] exp_v);
      checks++;
      assert (bus.imm_src === exp_v) else begin
         errors++;
         $error("FAIL %s got=%0b exp=%0b", tag, bus.imm_src, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input logic mr);
      bus.op       = o;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
      bus.zero     = z;
      bus.mem_ready = mr;
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      set_in(7'b0000011, 3'b000, 1'b0, 1'b0, 1'b1);
      #2;
      // reset: FETCH with strobes forced low although mem_ready=1
      chk("reset", ev(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));
      #9;
      rst_n = 1'b1;
      #1;
      // lw, mem_ready=1: 0,1,2,3,4,0
      chk("lw_fetch", ev(4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));
      chk_imm("lw_imm", 2'b00);
      cyc(); chk("lw_decode", ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0));
      cyc(); chk("lw_memadr", ev(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
      cyc(); chk("lw_memread", ev(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      cyc(); chk("lw_memwb", ev(4'd4, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 0));
      cyc(); chk("lw_done", ev(4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));

      // FETCH stall: no pc/ir write and no advance while mem_ready=0
      set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
      chk("fetch_stall", ev(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));
      chk_imm("sw_imm", 2'b01);
      cyc(); chk("fetch_hold", ev(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));

      // sw with two wait cycles in MEMWRITE
      set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
      cyc(); chk("sw_decode", ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0));
      cyc(); chk("sw_memadr", ev(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
      set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
      cyc(); chk("sw_wr1", ev(4'd5, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      cyc(); chk("sw_wr2", ev(4'd5, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
      chk("sw_wr3", ev(4'd5, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      cyc(); chk("sw_done", ev(4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));

      // R-type sub
      set_in(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
      cyc(); chk("rsub_decode", ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0));
      cyc(); chk("rsub_exec", ev(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0));
      cyc(); chk("rsub_aluwb", ev(4'd7, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      cyc(); chk("rsub_done", ev(4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));

      // R-type and
      set_in(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b1);
      cyc(); cyc();
      chk("rand_exec", ev(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 0));
      cyc(); chk("rand_aluwb", ev(4'd7, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      cyc();

      // I-ALU: funct7b5 ignored for funct3=000 (addi), then slt and or
      set_in(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
      cyc(); cyc();
      chk("addi_exec", ev(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
      set_in(7'b0010011, 3'b010, 1'b0, 1'b0, 1'b1);
      chk("slti_exec", ev(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 0));
      set_in(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b1);
      chk("ori_exec", ev(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b011, 0));
      cyc(); chk("i_aluwb", ev(4'd7, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      cyc();

      // jal
      set_in(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
      chk_imm("jal_imm", 2'b11);
      cyc(); cyc();
      chk("jal_state", ev(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0));
      cyc(); chk("jal_aluwb", ev(4'd7, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      cyc(); chk("jal_done", ev(4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));

      // beq taken
      set_in(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1);
      chk_imm("beq_imm", 2'b10);
      cyc(); cyc();
      chk("beq_taken", ev(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0));
      cyc(); chk("beq_t_done", ev(4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));

      // beq not taken
      set_in(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1);
      cyc(); cyc();
      chk("beq_not", ev(4'd10, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0));
      cyc(); chk("beq_n_done", ev(4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));

      // illegal opcode
      set_in(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
      chk_imm("ill_imm", 2'b00);
      cyc(); chk("ill_decode", ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 1));
      cyc(); chk("ill_fetch", ev(4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));

      // reset asserted mid-store while mem_write is high
      set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
      cyc(); cyc();
      set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
      cyc(); chk("rst_pre", ev(4'd5, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      rst_n = 1'b0;
      #1;
      chk("rst_async", ev(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));
      set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
      chk("rst_force", ev(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));
      cyc(); chk("rst_hold", ev(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));
      rst_n = 1'b1;
      #1;
      chk("rst_release", ev(4'd0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0));
      cyc(); chk("rst_decode", ev(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
- REQ-001: The block SHALL have no parameters; the opcode set, state encoding and control encodings are fixed by this document.
- REQ-002: The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-003: The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-004: The block SHALL have port op, input, 7 bits: instr[6:0] from the instruction register.
- REQ-005: The block SHALL have port funct3, input, 3 bits: instr[14:12].
- REQ-006: The block SHALL have port funct7b5, input, 1 bit: instr[30].
- REQ-007: The block SHALL have port zero, input, 1 bit: ALU zero flag.
- REQ-008: The block SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
- REQ-009: The block SHALL have outputs pc_write, ir_write, reg_write, mem_write and adr_src, each 1 bit.
- REQ-010: The block SHALL have outputs result_src, alu_src_a, alu_src_b and imm_src, each 2 bits.
- REQ-011: The block SHALL have outputs alu_control (3 bits), illegal (1-bit pulse) and state (4-bit debug, current state).

Function
- REQ-012: Opcodes SHALL be: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- REQ-013: The state encoding SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10.
- REQ-014: State transitions SHALL be:
  - FETCH->DECODE only when mem_ready=1, else stay in FETCH.
  - DECODE->MEMADR (lw/sw), EXECUTER, EXECUTEI, JAL or BEQ by op.
  - MEMADR->MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD->MEMWB on mem_ready, else stay; MEMWB->FETCH.
  - MEMWRITE->FETCH on mem_ready, else stay.
  - EXECUTER and EXECUTEI->ALUWB; JAL->ALUWB; ALUWB->FETCH; BEQ->FETCH.
  - Unused encodings 11-15 ->FETCH.
- REQ-015: In DECODE, an op not in REQ-012 SHALL pulse illegal=1 for that cycle and transition to FETCH.
- REQ-016: All outputs except imm_src SHALL be Moore decodes of state, qualified by mem_ready/zero where stated; any output not listed for a state is 0.
- REQ-017: FETCH SHALL drive adr_src=0, alu_src_a=00, alu_src_b=10, ALU add, result_src=10, and ir_write=pc_write=mem_ready.
- REQ-018: DECODE SHALL drive alu_src_a=01, alu_src_b=01, ALU add.
- REQ-019: MEMADR SHALL drive alu_src_a=10, alu_src_b=01, ALU add.
- REQ-020: MEMREAD SHALL drive adr_src=1, result_src=00.
- REQ-021: MEMWB SHALL drive result_src=01, reg_write=1.
- REQ-022: MEMWRITE SHALL drive adr_src=1, result_src=00, and hold mem_write=1 every cycle until and including the mem_ready cycle.
- REQ-023: EXECUTER SHALL drive alu_src_a=10, alu_src_b=00, functional ALU decode; EXECUTEI SHALL drive alu_src_a=10, alu_src_b=01, functional ALU decode.
- REQ-024: ALUWB SHALL drive result_src=00, reg_write=1.
- REQ-025: JAL SHALL drive alu_src_a=01, alu_src_b=10, ALU add, result_src=00, pc_write=1.
- REQ-026: BEQ SHALL drive alu_src_a=10, alu_src_b=00, ALU sub, result_src=00, pc_write=zero.
- REQ-027: alu_control codes SHALL be: add 000, sub 001, and 010, or 011, slt 101.
- REQ-028: Functional ALU decode SHALL map funct3 000 to sub if (funct7b5 & op[5]), else add; 010->slt; 110->or; 111->and; any other funct3->add.
- REQ-029: imm_src SHALL be combinational from op in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- REQ-030: Instruction latency SHALL be, with mem_ready=1 throughout: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles, counting from FETCH entry to the next FETCH entry.

Reset
- REQ-031: While rst_n=0, state SHALL be FETCH and pc_write, ir_write, reg_write, mem_write and illegal SHALL be forced to 0, regardless of mem_ready.
- REQ-032: Deassertion of rst_n SHALL take effect at the next clk edge; an assertion mid-instruction SHALL abandon it immediately, with no write strobe in that cycle.

Verification
- REQ-033: Bench SHALL cover lw (op=0000011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01.
- REQ-034: Bench SHALL cover sw with mem_ready low 2 cycles in MEMWRITE -> mem_write=1 for 3 consecutive cycles, adr_src=1, then FETCH.
- REQ-035: Bench SHALL cover R-type funct3=000, funct7b5=1 -> EXECUTER alu_control=001; with funct3=111 -> 010; ALUWB reg_write=1.
- REQ-036: Bench SHALL cover beq with zero=1 -> pc_write=1 in state 10; with zero=0 -> pc_write=0; next state 0 in both cases.
- REQ-037: Bench SHALL cover op=1111111 -> illegal=1 in DECODE for one cycle, then state 0, with no write strobes.
- REQ-038: Bench SHALL cover rst_n pulled low in state 5 with mem_write=1 -> mem_write=0 and state=0 asynchronously, before the next clk edge.
